shift_reg_sched: RTL and testbench

Two-port scheduler that shares one 8-bit shift register between two requesters, such as the counter and adder paths. It grants the register to one requester at a time using round-robin arbitration. It loads the winner's operand, shifts it left by a requested amount, and flags completion. The block owns the register, so `out` is the shared datapath value consumed downstream.

---
 rtl/shift_reg_sched_if.sv | 44 ++++
 rtl/shift_reg_sched.sv | 125 ++++++++++++
 tb/tb_shift_reg_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_sched_if.sv
// ---------------------------------------------------------------------------
// shift_reg_sched_if
//   Bundle of the request/grant and result signals between two requesters
//   and the shift_reg_sched scheduler.
//
//   Parameters : WIDTH  operand / register width
//                CNT_W  width of shift-amount fields
//   Signals    : req0/req1    request levels
//                data0/data1  operands
//                amt0/amt1    shift amounts
//                gnt0/gnt1    one-cycle grant pulses
//                owner        requester index of current/last result
//                busy         scheduler not idle
//                done         one-cycle completion pulse
//                out          shared register contents
//   Modports   : master (requester side), slave (scheduler side)
// ---------------------------------------------------------------------------
interface shift_reg_sched_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic [CNT_W-1:0] amt0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic [CNT_W-1:0] amt1;
  logic             gnt0;
  logic             gnt1;
  logic             owner;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output req0, data0, amt0, req1, data1, amt1,
    input  gnt0, gnt1, owner, busy, done, out
  );

  modport slave (
    input  req0, data0, amt0, req1, data1, amt1,
    output gnt0, gnt1, owner, busy, done, out
  );
endinterface

// File: rtl/shift_reg_sched.sv
// ---------------------------------------------------------------------------
// shift_reg_sched
//   Shares one shift register between two requesters. A round-robin arbiter
//   picks a winner in IDLE, the winner's operand is loaded and shifted left
//   one position per cycle by the requested amount, and done flags the
//   finished result for one cycle.
//
//   Ports : clock  rising-edge clock
//           rsnt   asynchronous active-low reset
//           bus    shift_reg_sched_if.slave (requests, grants, result)
//
//   Build option : define SHIFT_ROTATE_EN to rotate left (MSB into LSB)
//                  instead of the default zero-filling logical shift.
// ---------------------------------------------------------------------------
module shift_reg_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic           clock,
  input  logic           rsnt,
  shift_reg_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;

  logic             any_req;
  logic             win;
  logic [WIDTH-1:0] win_data;
  logic [CNT_W-1:0] win_amt;
  logic [WIDTH-1:0] shifted;

  // Pointer only breaks ties; a lone request wins outright.
  assign any_req  = bus.req0 | bus.req1;
  assign win      = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
  assign win_data = win ? bus.data1 : bus.data0;
  assign win_amt  = win ? bus.amt1  : bus.amt0;

  // One position per cycle; amounts >= WIDTH therefore fall out naturally
  // (all zeros when shifting, modulo WIDTH when rotating).
`ifdef SHIFT_ROTATE_EN
  assign shifted = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
`else
  assign shifted = {out_q[WIDTH-2:0], 1'b0};
`endif

  // NOTE: every _d gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          out_d   = win_data;
          count_d = win_amt;
          owner_d = win;
          ptr_d   = ~win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          if (win_amt == '0) state_d = DONE;
          else               state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_d   = shifted;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge rsnt) begin
    if (!rsnt) begin
      state_q <= IDLE;
      out_q   <= '0;
      count_q <= '0;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.owner = owner_q;
  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_shift_reg_sched.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_sched
//   Self-checking bench for shift_reg_sched. Expected results are queued
//   when a request is driven and compared when done pulses.
//   Honours SHIFT_ROTATE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_shift_reg_sched;

  typedef struct packed {
    logic       owner;
    logic [7:0] val;
  } exp_t;

  logic clock;
  logic rsnt;
  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb_q[$];

  shift_reg_sched_if #(.WIDTH(8), .CNT_W(3)) bus ();

  shift_reg_sched #(.WIDTH(8), .CNT_W(3)) dut (
    .clock (clock),
    .rsnt  (rsnt),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference result of shifting d left by a positions.
  function automatic logic [7:0] model(input logic [7:0] d, input int a);
`ifdef SHIFT_ROTATE_EN
    int r;
    r = a % 8;
    if (r == 0) return d;
    return (d << r) | (d >> (8 - r));
`else
    if (a >= 8) return 8'h00;
    return d << a;
`endif
  endfunction

  // Scoreboard consumer and grant exclusivity monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.gnt0 | bus.gnt1) chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_out",   32'(bus.out),   32'(e.val));
          chk("done_owner", 32'(bus.owner), 32'(e.owner));
        end
      end
    end
  end

  // Drive one request, wait (bounded) for its grant, check the accept cycle.
  task automatic do_op(input bit port, input logic [7:0] d, input logic [2:0] a,
                       input bit expect_done);
    bit seen;
    if (expect_done) sb_q.push_back('{owner: port, val: model(d, int'(a))});
    if (port) begin
      bus.data1 = d; bus.amt1 = a; bus.req1 = 1'b1;
    end else begin
      bus.data0 = d; bus.amt0 = a; bus.req0 = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (port ? bus.gnt1 : bus.gnt0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("gnt_seen",    32'(seen),     32'd1);
    chk("accept_out",  32'(bus.out),  32'(d));
    chk("accept_busy", 32'(bus.busy), 32'd1);
    if (port) bus.req1 = 1'b0;
    else      bus.req0 = 1'b0;
  endtask

  // Wait (bounded) for the scheduler to go idle with the scoreboard empty.
  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (sb_q.size() == 0 && bus.busy == 1'b0) break;
    end
    chk("drain_sb",   32'(sb_q.size()), 32'd0);
    chk("drain_busy", 32'(bus.busy),    32'd0);
  endtask

  initial begin
    logic [7:0] s3_seq[3];
    logic [7:0] rot_exp;
    int         ngr;
    bit         rr_exp;

`ifdef SHIFT_ROTATE_EN
    s3_seq  = '{8'hB4, 8'h69, 8'hD2};
    rot_exp = 8'h03;
`else
    s3_seq  = '{8'hB4, 8'h68, 8'hD0};
    rot_exp = 8'h02;
`endif

    rsnt = 1'b0;
    bus.req0 = 1'b0; bus.data0 = '0; bus.amt0 = '0;
    bus.req1 = 1'b0; bus.data1 = '0; bus.amt1 = '0;

    // Reset, then 10 idle cycles with nothing happening.
    repeat (3) @(negedge clock);
    chk("rst_out",  32'(bus.out),   32'd0);
    chk("rst_busy", 32'(bus.busy),  32'd0);
    chk("rst_own",  32'(bus.owner), 32'd0);
    rsnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_out",  32'(bus.out),  32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_gnt",  32'(bus.gnt0 | bus.gnt1), 32'd0);
    end

    // Shift by 3 from requester 0.
    do_op(1'b0, 8'h5A, 3'd3, 1'b1);
    chk("s3_done_early", 32'(bus.done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("s3_out",  32'(bus.out),  32'(s3_seq[i]));
      chk("s3_done", 32'(bus.done), (i == 2) ? 32'd1 : 32'd0);
    end
    chk("s3_owner", 32'(bus.owner), 32'd0);
    @(posedge clock); #1;
    chk("s3_hold_out", 32'(bus.out),  32'(s3_seq[2]));
    chk("s3_idle",     32'(bus.busy), 32'd0);
    drain();

    // Zero amount from requester 1: done in the grant cycle.
    do_op(1'b1, 8'hC3, 3'd0, 1'b1);
    chk("z_done",  32'(bus.done),  32'd1);
    chk("z_out",   32'(bus.out),   32'hC3);
    chk("z_owner", 32'(bus.owner), 32'd1);
    drain();

    // Round-robin with both requests held; pointer is 0 here.
    bus.data0 = 8'h11; bus.amt0 = 3'd0;
    bus.data1 = 8'h22; bus.amt1 = 3'd0;
    sb_q.push_back('{owner: 1'b0, val: 8'h11});
    sb_q.push_back('{owner: 1'b1, val: 8'h22});
    sb_q.push_back('{owner: 1'b0, val: 8'h11});
    sb_q.push_back('{owner: 1'b1, val: 8'h22});
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    ngr = 0;
    rr_exp = 1'b0;
    for (int i = 0; i < 40 && ngr < 4; i++) begin
      @(posedge clock); #1;
      if (bus.gnt0 | bus.gnt1) begin
        chk("rr_grant", 32'(bus.gnt1), 32'(rr_exp));
        rr_exp = ~rr_exp;
        ngr++;
      end
    end
    chk("rr_count", 32'(ngr), 32'd4);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    drain();

    // Reset in the middle of a shift: no done, everything back to zero.
    do_op(1'b0, 8'h81, 3'd7, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("mid_out", 32'(bus.out), 32'(model(8'h81, 2)));
    rsnt = 1'b0;
    #1;
    chk("mid_rst_out",  32'(bus.out),   32'd0);
    chk("mid_rst_busy", 32'(bus.busy),  32'd0);
    chk("mid_rst_done", 32'(bus.done),  32'd0);
    chk("mid_rst_own",  32'(bus.owner), 32'd0);
    repeat (3) @(negedge clock);
    rsnt = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    // Simultaneous request after reset: pointer is 0, so requester 0 first.
    bus.data0 = 8'h11; bus.amt0 = 3'd0;
    bus.data1 = 8'h22; bus.amt1 = 3'd0;
    sb_q.push_back('{owner: 1'b0, val: 8'h11});
    sb_q.push_back('{owner: 1'b1, val: 8'h22});
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    ngr = 0;
    for (int i = 0; i < 20 && ngr < 2; i++) begin
      @(posedge clock); #1;
      if (bus.gnt0 | bus.gnt1) begin
        chk("post_rst_grant", 32'(bus.gnt1), (ngr == 0) ? 32'd0 : 32'd1);
        if (bus.gnt0) bus.req0 = 1'b0;
        if (bus.gnt1) bus.req1 = 1'b0;
        ngr++;
      end
    end
    chk("post_rst_count", 32'(ngr), 32'd2);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    drain();

    // Rotate-vs-shift distinguishing case.
    do_op(1'b0, 8'h81, 3'd1, 1'b1);
    @(posedge clock); #1;
    chk("rot_done", 32'(bus.done), 32'd1);
    chk("rot_out",  32'(bus.out),  32'(rot_exp));
    drain();

    // A few random single-requester operations.
    for (int i = 0; i < 6; i++) begin
      do_op(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)), 1'b1);
      drain();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
